fifo_wr_ctrl: RTL and testbench

Write-domain pointer and flag controller for the async FIFO.
- Accepts write requests and produces the write address and write-enable qualification (full flag) for the FIFO memory.
- Publishes the Gray-coded write pointer for the read domain.
- Synchronizes the read domain's Gray pointer into w_clk.
- Provides fill level, almost-full and sticky overflow status to the producer.

---
 rtl/fifo_wr_ctrl.sv | 101 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-domain pointer, full/level and overflow controller for the async FIFO
// Synchronizes the read Gray pointer and derives full, level and almost-full from it pessimistically.
module fifo_wr_ctrl #(
  parameter int A_SIZE      = 3,
  parameter int P_SIZE      = A_SIZE + 1,
  parameter int AF_LEVEL    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_inc,
  input  logic              w_ovf_clr,
  input  logic [P_SIZE-1:0] r_gptr,
  output logic [A_SIZE-1:0] w_addr,
  output logic [P_SIZE-1:0] w_gptr,
  output logic              w_full,
  output logic              w_almost_full,
  output logic [P_SIZE-1:0] w_level,
  output logic              w_ovf
);

  localparam logic [P_SIZE-1:0] AF_THRESH = P_SIZE'(AF_LEVEL);

  logic [P_SIZE-1:0] sync_q [SYNC_STAGES];
  logic [P_SIZE-1:0] sync_d [SYNC_STAGES];
  logic [P_SIZE-1:0] rq_g;
  logic [P_SIZE-1:0] rq_b;

  logic [P_SIZE-1:0] wbin_q, wbin_d;
  logic [P_SIZE-1:0] gptr_q, gptr_d;
  logic [P_SIZE-1:0] level_q, level_d;
  logic              full_q, full_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              push;

  always_comb begin
    sync_d[0] = r_gptr;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rq_g = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rq_b = '0;
    for (int i = 0; i < P_SIZE; i++) begin
      rq_b[i] = ^(rq_g >> i);
    end
  end

  always_comb begin
    push    = w_inc & ~full_q;
    wbin_d  = wbin_q + {{(P_SIZE-1){1'b0}}, push};
    gptr_d  = wbin_d ^ (wbin_d >> 1);
    // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
    full_d  = (gptr_d == {~rq_g[P_SIZE-1:P_SIZE-2], rq_g[P_SIZE-3:0]});
    level_d = wbin_d - rq_b;
    af_d    = (level_d >= AF_THRESH);
    ovf_d   = ovf_q;
    if (w_inc & full_q) begin
      ovf_d = 1'b1;
    end else if (w_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      wbin_q  <= '0;
      gptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      wbin_q  <= wbin_d;
      gptr_q  <= gptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_addr        = wbin_q[A_SIZE-1:0];
  assign w_gptr        = gptr_q;
  assign w_full        = full_q;
  assign w_almost_full = af_q;
  assign w_level       = level_q;
  assign w_ovf         = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - scoreboard bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;
  localparam int A  = 3;
  localparam int P  = 4;
  localparam int AF = 6;
  localparam int SS = 2;

  logic         w_clk = 1'b0;
  logic         w_rst;
  logic         w_inc;
  logic         w_ovf_clr;
  logic [P-1:0] r_gptr;
  logic [A-1:0] w_addr;
  logic [P-1:0] w_gptr;
  logic         w_full;
  logic         w_almost_full;
  logic [P-1:0] w_level;
  logic         w_ovf;

  fifo_wr_ctrl #(.A_SIZE(A), .P_SIZE(P), .AF_LEVEL(AF), .SYNC_STAGES(SS)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_inc(w_inc), .w_ovf_clr(w_ovf_clr), .r_gptr(r_gptr),
    .w_addr(w_addr), .w_gptr(w_gptr), .w_full(w_full), .w_almost_full(w_almost_full),
    .w_level(w_level), .w_ovf(w_ovf)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [P-1:0] gptr;
    logic         full;
    logic         af;
    logic [P-1:0] level;
    logic         ovf;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wcnt, rcnt;
  int   rh[SS];
  bit   m_full, m_ovf;

  function automatic logic [P-1:0] gray(input int v);
    logic [P-1:0] b;
    b = P'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.addr = w_addr; o.gptr = w_gptr; o.full = w_full;
    o.af = w_almost_full; o.level = w_level; o.ovf = w_ovf;
    return o;
  endfunction

  task automatic model_reset();
    wcnt = 0; rcnt = 0; m_full = 0; m_ovf = 0;
    for (int i = 0; i < SS; i++) rh[i] = 0;
    exp_q.delete();
  endtask

  // Drives one cycle, predicts the post-edge outputs and queues them.
  task automatic cycle(input bit inc, input bit clr);
    int   rs, lvl;
    bit   push;
    obs_t e;
    @(negedge w_clk);
    w_inc = inc; w_ovf_clr = clr; r_gptr = gray(rcnt);
    push = inc && !m_full;
    if (inc && m_full) m_ovf = 1;
    else if (clr) m_ovf = 0;
    wcnt = (wcnt + int'(push)) % 16;
    rs = rh[SS-1];
    for (int i = SS-1; i > 0; i--) rh[i] = rh[i-1];
    rh[0] = rcnt;
    lvl = (((wcnt - rs) % 16) + 16) % 16;
    m_full = (lvl == 8);
    e.addr = A'(wcnt % 8); e.gptr = gray(wcnt); e.full = m_full;
    e.af = (lvl >= AF); e.level = P'(lvl); e.ovf = m_ovf;
    exp_q.push_back(e);
    @(posedge w_clk); #1;
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    w_rst = 1; w_inc = 0; w_ovf_clr = 0; r_gptr = '0;
    model_reset();
    @(negedge w_clk);
    w_rst = 0;
  endtask

  task automatic fill_full(input string tag);
    obs_t e, g;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s_fill[%0d] got %h exp %h", tag, i, g, e); end
    end
  endtask

  task automatic test_reset();
    obs_t e, g;
    w_rst = 1; w_inc = 0; w_ovf_clr = 0; r_gptr = '0;
    model_reset();
    #2;
    checks++;
    if (observe() !== '0) begin errors++; $display("FAIL reset_init got %h exp 0", observe()); end
    @(negedge w_clk); w_rst = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_burst[%0d] got %h exp %h", i, g, e); end
    end
    @(negedge w_clk); #2;
    w_rst = 1;
    #1;
    checks++;
    if (observe() !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", observe()); end
    model_reset();
    w_inc = 0;
    @(negedge w_clk); w_rst = 0;
    checks++;
    if (w_addr !== '0) begin errors++; $display("FAIL reset_first_addr got %0d exp 0", w_addr); end
    cycle(1, 0);
    e = exp_q.pop_front(); g = observe(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_first_push got %h exp %h", g, e); end
    checks++;
    if (w_gptr !== 4'b0001) begin errors++; $display("FAIL reset_first_gptr got %b exp 0001", w_gptr); end
  endtask

  task automatic test_fill();
    logic [P-1:0] gtab [8];
    obs_t e, g;
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (w_addr !== A'(i) || w_gptr !== gtab[i]) begin
        errors++; $display("FAIL fill_pre[%0d] got addr %0d gptr %b exp addr %0d gptr %b", i, w_addr, w_gptr, i, gtab[i]);
      end
      cycle(1, 0);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin errors++; $display("FAIL fill[%0d] got %h exp %h", i, g, e); end
      checks++;
      if (w_level !== P'(i+1) || w_almost_full !== (i >= 5) || w_full !== (i == 7)) begin
        errors++; $display("FAIL fill_flags[%0d] got lvl %0d af %b full %b", i, w_level, w_almost_full, w_full);
      end
    end
    checks++;
    if (w_gptr !== 4'b1100) begin errors++; $display("FAIL fill_gptr_end got %b exp 1100", w_gptr); end
  endtask

  task automatic test_overflow();
    obs_t e, g;
    bit   incs [5] = '{1, 1, 0, 1, 0};
    bit   clrs [5] = '{0, 0, 1, 1, 0};
    bit   ovfx [5] = '{1, 1, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      cycle(incs[i], clrs[i]);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin errors++; $display("FAIL ovf[%0d] got %h exp %h", i, g, e); end
      checks++;
      if (w_ovf !== ovfx[i] || w_level !== 4'd8 || w_gptr !== 4'b1100 || w_full !== 1'b1) begin
        errors++; $display("FAIL ovf_state[%0d] got ovf %b lvl %0d gptr %b full %b exp ovf %b", i, w_ovf, w_level, w_gptr, w_full, ovfx[i]);
      end
    end
  endtask

  task automatic test_drain();
    obs_t e, g;
    do_reset();
    fill_full("drain");
    rcnt = 1;
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin errors++; $display("FAIL drain[%0d] got %h exp %h", k, g, e); end
      checks++;
      if (w_full !== (k < 3) || w_level !== ((k < 3) ? 4'd8 : 4'd7)) begin
        errors++; $display("FAIL drain_lat[%0d] got full %b lvl %0d exp full %b", k, w_full, w_level, k < 3);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t         e, g;
    logic [P-1:0] prev;
    bit           wrapped = 0;
    int           false_full = 0;
    do_reset();
    cycle(1, 0);
    e = exp_q.pop_front(); g = observe(); checks++;
    if (g !== e) begin errors++; $display("FAIL wrap_first got %h exp %h", g, e); end
    for (int p = 0; p < 20; p++) begin
      rcnt = wcnt;
      prev = w_gptr;
      cycle(1, 0);
      if (prev == 4'b1000 && w_gptr == 4'b0000) wrapped = 1;
      for (int j = 0; j < 4; j++) begin
        if (j > 0) cycle(0, 0);
        e = exp_q.pop_front(); g = observe(); checks++;
        if (g !== e) begin errors++; $display("FAIL wrap[%0d.%0d] got %h exp %h", p, j, g, e); end
        if (w_full) false_full++;
      end
    end
    checks++;
    if (false_full != 0) begin errors++; $display("FAIL wrap_no_full got %0d full cycles exp 0", false_full); end
    checks++;
    if (!wrapped) begin errors++; $display("FAIL wrap_1000_to_0000 got no wrap exp wrap"); end
    checks++;
    if (w_level !== 4'd1 || w_gptr !== 4'b0111) begin
      errors++; $display("FAIL wrap_end got lvl %0d gptr %b exp lvl 1 gptr 0111", w_level, w_gptr);
    end
  endtask

  task automatic test_simul();
    obs_t e, g;
    bit   full_pre;
    bit   done = 0;
    do_reset();
    fill_full("simul");
    rcnt = 1;
    for (int k = 1; k <= 6 && !done; k++) begin
      full_pre = w_full;
      cycle(1, 0);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin errors++; $display("FAIL simul[%0d] got %h exp %h", k, g, e); end
      if (!full_pre) begin
        done = 1;
        checks++;
        if (k != 4 || w_full !== 1'b1 || w_level !== 4'd8 || w_addr !== 3'd1) begin
          errors++; $display("FAIL simul_accept got edge %0d full %b lvl %0d addr %0d exp edge 4 full 1 lvl 8 addr 1", k, w_full, w_level, w_addr);
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL simul_timeout got full held exp push accepted within 6 edges");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_simul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
